// File: rtl/pipe_scoreboard_ctrl_pkg.sv
// Shared types and defaults for the register scoreboard / stall sequencer.
// Entry width is fixed here so every entry and the top agree on the latency counter size.
package pipe_scoreboard_ctrl_pkg;

    localparam int SB_NREG        = 32;
    localparam int SB_RIDX_W      = 5;
    localparam int SB_LAT_W       = 3;
    localparam int SB_STALL_LIMIT = 64;

    typedef logic [SB_LAT_W-1:0] lat_t;

    typedef struct packed {
        logic pending;
        lat_t cnt;
    } sb_entry_t;

    function automatic lat_t sat_dec(input lat_t v);
        return (v == '0) ? '0 : v - lat_t'(1);
    endfunction

endpackage

// File: rtl/pipe_scoreboard_ctrl_if.sv
// ID-stage / writeback / pipe-control bundle between the pipeline (master)
// and the scoreboard controller (slave).
interface pipe_scoreboard_ctrl_if
    import pipe_scoreboard_ctrl_pkg::*;
#(
    parameter int RIDX_W = SB_RIDX_W,
    parameter int LAT_W  = SB_LAT_W
) ();

    logic              id_valid;
    logic [RIDX_W-1:0] id_rs1;
    logic [RIDX_W-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [RIDX_W-1:0] id_rd;
    logic              id_we;
    logic [LAT_W-1:0]  id_lat;
    logic              wb_valid;
    logic [RIDX_W-1:0] wb_rd;
    logic              mem_busy;
    logic              flush;

    logic              id_fire;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              hazard_o;
    logic              deadlock_o;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_we, id_lat, wb_valid, wb_rd, mem_busy, flush,
        input  id_fire, stall_if, stall_id, bubble_ex, hazard_o, deadlock_o
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_we, id_lat, wb_valid, wb_rd, mem_busy, flush,
        output id_fire, stall_if, stall_id, bubble_ex, hazard_o, deadlock_o
    );

endinterface

// File: rtl/pipe_scoreboard_ctrl_sb_entry.sv
// One architectural register's pending flag and remaining-bubble count.
// Priority: issue (set) beats writeback/flush (clr) beats the per-cycle decrement.
module sb_entry
    import pipe_scoreboard_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set,
    input  lat_t      set_lat,
    input  logic      clr,
    input  logic      dec,
    output sb_entry_t q
);

    sb_entry_t r_entry;

    // set is already gated off by flush at the top, so set-over-clr is safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
        end else if (set) begin
            r_entry.pending <= 1'b1;
            r_entry.cnt     <= set_lat;
        end else if (clr) begin
            r_entry <= '0;
        end else if (dec) begin
            r_entry.cnt <= sat_dec(r_entry.cnt);
        end
    end

    assign q = r_entry;

endmodule

// File: rtl/pipe_scoreboard_ctrl.sv
// Per-register pending/latency scoreboard beside ID: decides issue, drives
// IF/ID stall and EX bubble, and flags stalls that never resolve.
module pipe_scoreboard_ctrl
    import pipe_scoreboard_ctrl_pkg::*;
#(
    parameter int NREG        = SB_NREG,
    parameter int RIDX_W      = SB_RIDX_W,
    parameter int LAT_W       = SB_LAT_W,
    parameter int STALL_LIMIT = SB_STALL_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipe_scoreboard_ctrl_if.slave  sb_if
);

    localparam int SR_W = $clog2(STALL_LIMIT) + 1;

    logic             w_pend [NREG];
    logic [LAT_W-1:0] w_cnt  [NREG];

    logic w_raw1;
    logic w_raw2;
    logic w_waw;
    logic w_hazard;
    logic w_stall;
    logic w_fire;
    logic w_dec;

    logic [SR_W-1:0] r_stall_run;
    logic [SR_W-1:0] w_stall_run_next;
    logic            r_deadlock;

    // x0 is hard-wired zero and can never be pending.
    assign w_pend[0] = 1'b0;
    assign w_cnt[0]  = '0;
    assign w_dec     = !sb_if.mem_busy;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_entry
            sb_entry_t w_q;
            logic      w_set;
            logic      w_clr;

            assign w_set = w_fire && sb_if.id_we && (sb_if.id_rd == RIDX_W'(gi));
            assign w_clr = sb_if.flush ||
                           (sb_if.wb_valid && (sb_if.wb_rd == RIDX_W'(gi)));

            sb_entry u_entry (
                .clk     (clk),
                .rst_n   (rst_n),
                .set     (w_set),
                .set_lat (sb_if.id_lat),
                .clr     (w_clr),
                .dec     (w_dec),
                .q       (w_q)
            );

            assign w_pend[gi] = w_q.pending;
            assign w_cnt[gi]  = w_q.cnt;
        end
    endgenerate

    assign w_raw1 = sb_if.id_use_rs1 && w_pend[sb_if.id_rs1] && (w_cnt[sb_if.id_rs1] != '0);
    assign w_raw2 = sb_if.id_use_rs2 && w_pend[sb_if.id_rs2] && (w_cnt[sb_if.id_rs2] != '0);

    // An older write that will land after this one must not be overtaken.
    assign w_waw  = sb_if.id_we && (sb_if.id_rd != '0) && w_pend[sb_if.id_rd] &&
                    (w_cnt[sb_if.id_rd] > sb_if.id_lat);

    assign w_hazard = sb_if.id_valid && (w_raw1 || w_raw2 || w_waw);
    assign w_stall  = w_hazard || sb_if.mem_busy;
    assign w_fire   = sb_if.id_valid && !w_hazard && !sb_if.mem_busy && !sb_if.flush;

    assign sb_if.id_fire    = w_fire;
    assign sb_if.stall_if   = w_stall;
    assign sb_if.stall_id   = w_stall;
    assign sb_if.bubble_ex  = w_hazard && !sb_if.mem_busy;
    assign sb_if.hazard_o   = w_hazard;
    assign sb_if.deadlock_o = r_deadlock;

    always_comb begin
        w_stall_run_next = '0;
        if (w_stall) begin
            if (r_stall_run >= SR_W'(STALL_LIMIT)) begin
                w_stall_run_next = SR_W'(STALL_LIMIT);
            end else begin
                w_stall_run_next = r_stall_run + SR_W'(1);
            end
        end
    end

    // deadlock_o is set on the same edge the run length reaches the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_run <= '0;
            r_deadlock  <= 1'b0;
        end else if (sb_if.flush) begin
            r_stall_run <= '0;
            r_deadlock  <= 1'b0;
        end else begin
            r_stall_run <= w_stall_run_next;
            if (w_stall_run_next == SR_W'(STALL_LIMIT)) begin
                r_deadlock <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard_ctrl.sv
// Self-checking bench: a reference scoreboard model predicts each cycle's
// controls into a queue, which is popped and compared at the falling edge.
module tb_pipe_scoreboard_ctrl;
    import pipe_scoreboard_ctrl_pkg::*;

    localparam int LIMIT = 64;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic [2:0] lat;
        logic       wbv;
        logic [4:0] wbrd;
        logic       busy;
        logic       flush;
    } stim_t;

    typedef struct {
        logic fire;
        logic stall;
        logic bubble;
        logic hazard;
        logic deadlock;
    } exp_t;

    logic clk;
    logic rst_n;

    pipe_scoreboard_ctrl_if sif ();

    pipe_scoreboard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb_if (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q[$];

    bit   mdl_pend [32];
    int   mdl_cnt  [32];
    int   mdl_run;
    bit   mdl_dl;

    logic obs_fire;
    logic obs_dl;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.v = 0; s.rs1 = 0; s.rs2 = 0; s.u1 = 0; s.u2 = 0; s.rd = 0; s.we = 0;
        s.lat = 0; s.wbv = 0; s.wbrd = 0; s.busy = 0; s.flush = 0;
        return s;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mdl_pend[r] = 0;
            mdl_cnt[r]  = 0;
        end
        mdl_run = 0;
        mdl_dl  = 0;
    endtask

    function automatic bit mdl_raw(input logic [4:0] rs, input logic use_it);
        return use_it && (rs != 0) && mdl_pend[rs] && (mdl_cnt[rs] != 0);
    endfunction

    function automatic exp_t model_expect(input stim_t s);
        exp_t e;
        bit   waw;
        waw        = s.we && (s.rd != 0) && mdl_pend[s.rd] && (mdl_cnt[s.rd] > int'(s.lat));
        e.hazard   = s.v && (mdl_raw(s.rs1, s.u1) || mdl_raw(s.rs2, s.u2) || waw);
        e.stall    = e.hazard || s.busy;
        e.bubble   = e.hazard && !s.busy;
        e.fire     = s.v && !e.hazard && !s.busy && !s.flush;
        e.deadlock = mdl_dl;
        return e;
    endfunction

    task automatic model_update(input stim_t s, input exp_t e);
        if (s.flush) begin
            model_clear();
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (e.fire && s.we && (int'(s.rd) == r)) begin
                    mdl_pend[r] = 1;
                    mdl_cnt[r]  = int'(s.lat);
                end else if (s.wbv && (int'(s.wbrd) == r)) begin
                    mdl_pend[r] = 0;
                    mdl_cnt[r]  = 0;
                end else if (!s.busy && mdl_cnt[r] > 0) begin
                    mdl_cnt[r] = mdl_cnt[r] - 1;
                end
            end
            if (e.stall) mdl_run = (mdl_run < LIMIT) ? mdl_run + 1 : LIMIT;
            else         mdl_run = 0;
            if (mdl_run == LIMIT) mdl_dl = 1;
        end
    endtask

    task automatic apply(input stim_t s);
        sif.id_valid   = s.v;
        sif.id_rs1     = s.rs1;
        sif.id_rs2     = s.rs2;
        sif.id_use_rs1 = s.u1;
        sif.id_use_rs2 = s.u2;
        sif.id_rd      = s.rd;
        sif.id_we      = s.we;
        sif.id_lat     = s.lat;
        sif.wb_valid   = s.wbv;
        sif.wb_rd      = s.wbrd;
        sif.mem_busy   = s.busy;
        sif.flush      = s.flush;
    endtask

    // One pipeline cycle: called at posedge+1, returns at the next posedge+1.
    task automatic step(input stim_t s);
        exp_t e;
        apply(s);
        exp_q.push_back(model_expect(s));
        @(negedge clk);
        e = exp_q.pop_front();
        check_val("id_fire",    sif.id_fire,    e.fire);
        check_val("stall_if",   sif.stall_if,   e.stall);
        check_val("stall_id",   sif.stall_id,   e.stall);
        check_val("bubble_ex",  sif.bubble_ex,  e.bubble);
        check_val("hazard_o",   sif.hazard_o,   e.hazard);
        check_val("deadlock_o", sif.deadlock_o, e.deadlock);
        obs_fire = sif.id_fire;
        obs_dl   = sif.deadlock_o;
        $display("t=%0t v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d we=%0b lat=%0d wb=%0b/%0d busy=%0b fl=%0b -> fire=%0b stall=%0b bub=%0b haz=%0b dl=%0b",
                 $time, s.v, s.rs1, s.u1, s.rs2, s.u2, s.rd, s.we, s.lat, s.wbv, s.wbrd,
                 s.busy, s.flush, sif.id_fire, sif.stall_id, sif.bubble_ex, sif.hazard_o,
                 sif.deadlock_o);
        @(posedge clk);
        model_update(s, e);
        #1;
    endtask

    // Hold s in ID until it fires; busy is forced high for attempts bf..bt.
    task automatic count_stalls(input stim_t s, input int bf, input int bt, output int n);
        stim_t t;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            t      = s;
            t.busy = (k >= bf) && (k <= bt);
            step(t);
            if (obs_fire) break;
            n++;
        end
    endtask

    // Producer on x11 then a consumer held under mem_busy until deadlock_o shows.
    task automatic run_deadlock(output int seen);
        stim_t s;
        s = idle(); s.v = 1; s.rd = 11; s.we = 1; s.lat = 7;
        step(s);
        s = idle(); s.v = 1; s.u1 = 1; s.rs1 = 11; s.busy = 1;
        seen = 0;
        for (int k = 1; k <= 70; k++) begin
            step(s);
            if (obs_dl === 1'b1) begin
                seen = k - 1;
                break;
            end
        end
    endtask

    initial begin
        stim_t s;
        int    n;

        rst_n = 1'b0;
        model_clear();
        apply(idle());
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_fire",     sif.id_fire,    0);
        check_val("rst_stall",    sif.stall_id,   0);
        check_val("rst_bubble",   sif.bubble_ex,  0);
        check_val("rst_hazard",   sif.hazard_o,   0);
        check_val("rst_deadlock", sif.deadlock_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load x5 (2 bubbles) then an immediate consumer.
        s = idle(); s.v = 1; s.rd = 5; s.we = 1; s.lat = 2;
        step(s);
        s = idle(); s.v = 1; s.u1 = 1; s.rs1 = 5; s.rd = 9; s.we = 1;
        count_stalls(s, 1, 0, n);
        check_val("load_raw_stalls", n, 2);

        // Forwardable ALU chain on x6: fires every cycle.
        n = 0;
        for (int k = 0; k < 5; k++) begin
            s = idle(); s.v = 1; s.u1 = (k != 0); s.rs1 = 6; s.rd = 6; s.we = 1;
            step(s);
            if (obs_fire) n++;
        end
        check_val("alu_chain_fires", n, 5);

        // WAW: lat-4 write on x7, then a lat-1 write at cnt=3.
        s = idle(); s.v = 1; s.rd = 7; s.we = 1; s.lat = 4;
        step(s);
        step(idle());
        s = idle(); s.v = 1; s.rd = 7; s.we = 1; s.lat = 1;
        count_stalls(s, 1, 0, n);
        check_val("waw_stalls", n, 2);

        // 2-bubble RAW on x10 with mem_busy for three cycles in the middle.
        s = idle(); s.v = 1; s.rd = 10; s.we = 1; s.lat = 2;
        step(s);
        s = idle(); s.v = 1; s.u2 = 1; s.rs2 = 10;
        count_stalls(s, 1, 3, n);
        check_val("busy_raw_stalls", n, 5);

        // Same-cycle writeback and issue on x8: the issue wins.
        s = idle(); s.v = 1; s.rd = 8; s.we = 1; s.lat = 3; s.wbv = 1; s.wbrd = 8;
        step(s);
        s = idle(); s.v = 1; s.u1 = 1; s.rs1 = 8;
        count_stalls(s, 1, 0, n);
        check_val("wb_vs_issue_stalls", n, 3);

        // Writes to x0 are ignored: a reader of x0 never stalls.
        s = idle(); s.v = 1; s.rd = 0; s.we = 1; s.lat = 5;
        step(s);
        s = idle(); s.v = 1; s.u1 = 1; s.rs1 = 0;
        step(s);
        check_val("x0_no_stall", obs_fire, 1);

        // Watchdog, then flush with a live instruction (fire suppressed).
        run_deadlock(n);
        check_val("deadlock_stalls", n, LIMIT);
        s = idle(); s.v = 1; s.rd = 12; s.we = 1; s.flush = 1;
        step(s);
        check_val("flush_no_fire", obs_fire, 0);
        s = idle(); s.v = 1; s.u1 = 1; s.rs1 = 11;
        step(s);
        check_val("post_flush_fire", obs_fire, 1);
        check_val("post_flush_dl", obs_dl, 0);

        // Watchdog again, then asynchronous reset mid-cycle.
        run_deadlock(n);
        check_val("deadlock_stalls2", n, LIMIT);
        s = idle(); s.v = 1; s.u1 = 1; s.rs1 = 11;
        apply(s);
        #2;
        check_val("pre_rst_hazard", sif.hazard_o, 1);
        rst_n = 1'b0;
        #1;
        check_val("arst_hazard",   sif.hazard_o,   0);
        check_val("arst_stall",    sif.stall_id,   0);
        check_val("arst_deadlock", sif.deadlock_o, 0);
        check_val("arst_fire",     sif.id_fire,    1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        step(s);

        // Random traffic over a few registers against the model.
        for (int k = 0; k < 60; k++) begin
            s       = idle();
            s.v     = ($urandom_range(0, 3) != 0);
            s.rs1   = 5'($urandom_range(0, 4));
            s.rs2   = 5'($urandom_range(0, 4));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.rd    = 5'($urandom_range(0, 4));
            s.we    = 1'($urandom_range(0, 1));
            s.lat   = 3'($urandom_range(0, 4));
            s.wbv   = ($urandom_range(0, 3) == 0);
            s.wbrd  = 5'($urandom_range(0, 4));
            s.busy  = ($urandom_range(0, 4) == 0);
            s.flush = ($urandom_range(0, 19) == 0);
            step(s);
        end

        check_val("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
